// File: rtl/ddr_deser_pkg.sv
// rtl/ddr_deser_pkg.sv - shared mode encodings and helpers for the dual-edge deserialiser
package ddr_deser_pkg;

  localparam logic [1:0] MODE_DDR  = 2'd0;
  localparam logic [1:0] MODE_RISE = 2'd1;
  localparam logic [1:0] MODE_FALL = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO with occupancy output
module sync_fifo_fwft import ddr_deser_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When empty the output shows the most recently popped word instead of a stale slot.
  assign head_data = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ddr_deser_n.sv
// rtl/ddr_deser_n.sv - multi-channel dual-edge capture, word packing and buffered readout
module ddr_deser_n import ddr_deser_pkg::*; #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH-1:0]          d,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   align,
  output logic [CH*W-1:0]        out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [clog2(DEPTH):0]  level,
  output logic                   ovf,
  output logic [7:0]             drop_cnt,
  input  logic                   clr_ovf
);

  localparam int CW = clog2(W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);

  logic [1:0]             mode_eff;
  logic [1:0]             mode_q;
  logic                   restart;
  logic [CH-1:0]          rise_q;
  logic [CH-1:0]          fall_q;
  logic                   cap_q;
  logic [CH-1:0][W-1:0]   shift_q;
  logic [CH-1:0][W-1:0]   shift_nxt;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_inc;
  logic [CW-1:0]          cnt_sum;
  logic                   word_done;
  logic [CH*W-1:0]        word_flat;
  logic [CH*W-1:0]        word_q;
  logic                   word_v;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   drop;

  assign mode_eff = (mode == MODE_RSVD) ? MODE_DDR : mode;
  assign restart  = align || (mode_eff != mode_q);

  // Fall samples are always taken; cap_q decides whether they are ever used.
  always_ff @(negedge clk) begin
    fall_q <= d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      cap_q  <= 1'b0;
      mode_q <= mode_eff;
    end else begin
      cap_q  <= en && !restart;
      mode_q <= mode_eff;
      if (en) rise_q <= d;
    end
  end

  // Shifting right so the first captured bit ends up in the LSB of the word.
  always_comb begin
    cnt_inc   = (mode_q == MODE_DDR) ? CW'(2) : CW'(1);
    cnt_sum   = cnt_q + cnt_inc;
    word_done = cap_q && (cnt_sum == CNT_FULL);
    shift_nxt = shift_q;
    word_flat = '0;
    for (int c = 0; c < CH; c++) begin
      case (mode_q)
        MODE_RISE: shift_nxt[c] = W'({rise_q[c], shift_q[c]} >> 1);
        MODE_FALL: shift_nxt[c] = W'({fall_q[c], shift_q[c]} >> 1);
        default:   shift_nxt[c] = W'({fall_q[c], rise_q[c], shift_q[c]} >> 2);
      endcase
      word_flat[c*W +: W] = shift_nxt[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      word_v  <= 1'b0;
    end else begin
      word_v <= word_done && !restart;
      if (word_done && !restart) word_q <= word_flat;
      if (restart) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (cap_q) begin
        shift_q <= shift_nxt;
        cnt_q   <= word_done ? '0 : cnt_sum;
      end
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = word_v && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (CH * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_v),
    .push_data (word_q),
    .pop       (pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule

// File: tb/tb_ddr_deser_n.sv
// tb/tb_ddr_deser_n.sv - directed self-checking bench for ddr_deser_n (CH=2, W=8, DEPTH=4)
module tb_ddr_deser_n;

  logic        clk;
  logic        rst;
  logic [1:0]  d;
  logic        en;
  logic [1:0]  mode;
  logic        align;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic        clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_deser_n #(.CH(2), .W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .en        (en),
    .mode      (mode),
    .align     (align),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts and ends just after a negedge: rise bit before posedge, fall bit before negedge.
  task automatic step(input logic [1:0] r, input logic [1:0] f, input logic e);
    en = e;
    d  = r;
    @(posedge clk);
    #1 d = f;
    @(negedge clk);
    #1;
  endtask

  // Channel 1 carries the inverse of channel 0 to exercise packing.
  task automatic bits(input logic rb, input logic fb);
    step({~rb, rb}, {~fb, fb}, 1'b1);
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 1'b0);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] v);
    for (int j = 0; j < 4; j++) bits(v[2*j], v[2*j+1]);
  endtask

  function automatic logic [15:0] exp_word(input logic [7:0] v);
    return {~v, v};
  endfunction

  logic [7:0] rise_pat;
  logic [7:0] drain_exp [4];

  initial begin
    rst = 1'b1; d = '0; en = 1'b0; mode = 2'd0; align = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    #1;
    idle();
    idle();
    rst = 1'b0;

    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_data", out_data, 0);

    for (int i = 0; i < 4; i++) bits(1'b1, 1'b0);
    idle();
    check("ddr_lat_early", out_valid, 0);
    idle();
    check("ddr_lat_valid", out_valid, 1);
    check("ddr_data", out_data, 16'hAA55);
    check("ddr_level", level, 1);
    pop_one();
    check("pop_empty", out_valid, 0);
    check("empty_hold", out_data, 16'hAA55);

    rise_pat = 8'b1100_1100;
    mode = 2'd1;
    idle();
    for (int i = 0; i < 8; i++) bits(rise_pat[7-i], ~rise_pat[7-i]);
    idle();
    check("rise_lat_early", out_valid, 0);
    idle();
    check("rise_valid", out_valid, 1);
    check("rise_data", out_data, 16'hCC33);
    pop_one();

    mode = 2'd2;
    idle();
    for (int i = 0; i < 8; i++) bits(~rise_pat[7-i], rise_pat[7-i]);
    idle();
    idle();
    check("fall_valid", out_valid, 1);
    check("fall_data", out_data, 16'hCC33);
    pop_one();

    mode = 2'd0;
    idle();
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h4B);
    send_word(8'h87);
    send_word(8'hE1);
    send_word(8'h5A);
    idle();
    idle();
    check("ovf_level", level, 4);
    check("ovf_flag", ovf, 1);
    check("ovf_drops", drop_cnt, 2);
    check("ovf_head", out_data, exp_word(8'h11));
    clr_ovf = 1'b1;
    idle();
    clr_ovf = 1'b0;
    check("clr_ovf", ovf, 0);
    check("clr_drops", drop_cnt, 0);

    send_word(8'hC3);
    idle();
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    check("pushpop_level", level, 4);
    check("pushpop_ovf", ovf, 0);
    check("pushpop_drops", drop_cnt, 0);
    drain_exp[0] = 8'h22; drain_exp[1] = 8'h4B; drain_exp[2] = 8'h87; drain_exp[3] = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", out_data, exp_word(drain_exp[i]));
      pop_one();
    end
    check("drain_level", level, 0);

    bits(1'b0, 1'b0);
    bits(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, 2'b11, 1'b0);
    bits(1'b1, 1'b1);
    bits(1'b0, 1'b1);
    idle();
    idle();
    check("en_gap_data", out_data, exp_word(8'hB4));
    check("en_gap_level", level, 1);
    pop_one();

    bits(1'b1, 1'b1);
    bits(1'b1, 1'b0);
    align = 1'b1;
    step(2'b01, 2'b01, 1'b1);
    align = 1'b0;
    send_word(8'h96);
    idle();
    idle();
    check("align_data", out_data, exp_word(8'h96));
    check("align_level", level, 1);
    pop_one();

    send_word(8'hFF);
    align = 1'b1;
    idle();
    align = 1'b0;
    idle();
    idle();
    check("align_prio_level", level, 0);
    check("align_prio_drops", drop_cnt, 0);

    send_word(8'h0F);
    send_word(8'hF0);
    idle();
    idle();
    check("pre_rst_level", level, 2);
    bits(1'b1, 1'b1);
    bits(1'b0, 1'b0);
    rst = 1'b1;
    step(2'b11, 2'b11, 1'b1);
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_data", out_data, 0);
    send_word(8'h3C);
    idle();
    check("post_rst_early", out_valid, 0);
    idle();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 16'hC33C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
